// File: rtl/npu_instr_issuer.sv
// Instruction issuer: walks CLR / MAC x (taps+1) / ACT per output for (outputs+1) outputs.
// Optional NPU_ISSUER_STALL_CNT_EN adds a saturating 16-bit back-pressure counter (stall_cnt).
module npu_instr_issuer #(
    parameter int W_IN      = 8,
    parameter int MUX_WIDTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [MUX_WIDTH-1:0] cfg_taps,
    input  logic [CNT_W-1:0]     cfg_outputs,
    input  logic                 cfg_relu,
    output logic [W_IN-1:0]      instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 busy,
    output logic                 done,
`ifdef NPU_ISSUER_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    output logic [2:0]           dbg_state
);

    // Handshake: an instruction moves on a rising edge where instr_valid and instr_ready are
    // both 1; once instr_valid is raised, instr stays stable and valid stays high until then.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_MAC  = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
    localparam logic [1:0] OP_ACT = 2'b11;

    state_t               state_q;
    logic [MUX_WIDTH-1:0] taps_q;
    logic [CNT_W-1:0]     outputs_q;
    logic                 relu_q;
    logic [MUX_WIDTH-1:0] tap_q;
    logic [CNT_W-1:0]     out_q;
    logic [W_IN-1:0]      instr_q;
    logic                 valid_q;
    logic                 done_q;
    logic [MUX_WIDTH-1:0] tap_d;

    function automatic logic [W_IN-1:0] enc(input logic [1:0] op, input logic mode,
                                            input logic [MUX_WIDTH-1:0] tap);
        logic [W_IN-1:0] v;
        v                = '0;
        v[7:6]           = op;
        v[4]             = mode;
        v[MUX_WIDTH-1:0] = tap;
        return v;
    endfunction

    assign tap_d = tap_q + 1'b1;

    // Outputs are computed for the state being entered, so they are registered and
    // the next instruction is already presented in the cycle after a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            taps_q    <= '0;
            outputs_q <= '0;
            relu_q    <= 1'b0;
            tap_q     <= '0;
            out_q     <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        taps_q    <= cfg_taps;
                        outputs_q <= cfg_outputs;
                        relu_q    <= cfg_relu;
                        tap_q     <= '0;
                        out_q     <= '0;
                        instr_q   <= enc(OP_CLR, 1'b0, '0);
                        valid_q   <= 1'b1;
                        state_q   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (instr_ready) begin
                        instr_q <= enc(OP_MAC, 1'b0, tap_q);
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (instr_ready) begin
                        if (tap_q == taps_q) begin
                            tap_q   <= '0;
                            instr_q <= enc(OP_ACT, relu_q, '0);
                            state_q <= S_ACT;
                        end else begin
                            tap_q   <= tap_d;
                            instr_q <= enc(OP_MAC, 1'b0, tap_d);
                        end
                    end
                end
                S_ACT: begin
                    if (instr_ready) begin
                        if (out_q == outputs_q) begin
                            instr_q <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            out_q   <= out_q + 1'b1;
                            instr_q <= enc(OP_CLR, 1'b0, '0);
                            state_q <= S_CLR;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef NPU_ISSUER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (valid_q && !instr_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule
